// File: rtl/logit_approx_pkg.sv
// Shared fixed-point helpers and FSM encoding for the logit approximation block.
package logit_approx_pkg;

   // Controller states: waiting for a sample, square-root iterations, result held.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Fixed-point 1.0 for a given number of fractional bits.
   function automatic int fp_one(input int frac_bits);
      return 32'sd1 << frac_bits;
   endfunction

   // Fixed-point 0.5 for a given number of fractional bits.
   function automatic int fp_half(input int frac_bits);
      return 32'sd1 << (frac_bits - 32'sd1);
   endfunction

endpackage

// File: rtl/logit_approx_isqrt_seq.sv
// Bit-serial restoring square root: one root bit per clock, RAD_WIDTH/2 steps.
// The first step is performed on the start edge itself so the root is complete
// RAD_WIDTH/2 - 1 edges later; done pulses for one cycle when it is.
module isqrt_seq
   import logit_approx_pkg::*;
#(
   parameter int RAD_WIDTH = 22
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [RAD_WIDTH-1:0]   radicand,
   output logic                   busy,
   output logic                   done,
   output logic [RAD_WIDTH/2-1:0] root
);

   localparam int ROOT_W = RAD_WIDTH / 2;
   localparam int REM_W  = ROOT_W + 2;
   localparam int CNT_W  = $clog2(ROOT_W);

   logic [RAD_WIDTH-1:0] rad_r;
   logic [REM_W-1:0]     rem_r;
   logic [ROOT_W-1:0]    root_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 busy_r;
   logic                 done_r;

   logic [REM_W-1:0]     rem_in_s;
   logic [ROOT_W-1:0]    root_in_s;
   logic [1:0]           pair_s;
   logic [REM_W+ROOT_W-1:0] step_s;

   // One restoring digit step: bring in two radicand bits, trial-subtract 4*root+1.
   // The remainder never exceeds 2*root, so the dropped upper bits are always zero.
   function automatic logic [REM_W+ROOT_W-1:0] sqrt_step(
      input logic [REM_W-1:0]  rem,
      input logic [ROOT_W-1:0] rt,
      input logic [1:0]        pair
   );
      logic [REM_W+1:0] shifted;
      logic [REM_W+2:0] trial;
      shifted = {rem, pair};
      trial   = {1'b0, shifted} - (REM_W+3)'({rt, 2'b01});
      if (trial[REM_W+2]) begin
         return {shifted[REM_W-1:0], rt[ROOT_W-2:0], 1'b0};
      end else begin
         return {trial[REM_W-1:0], rt[ROOT_W-2:0], 1'b1};
      end
   endfunction

   // Select step operands: fresh radicand on start, running state otherwise.
   always_comb begin
      rem_in_s  = '0;
      root_in_s = '0;
      pair_s    = 2'b00;
      if (start) begin
         rem_in_s  = '0;
         root_in_s = '0;
         pair_s    = radicand[RAD_WIDTH-1 -: 2];
      end else begin
         rem_in_s  = rem_r;
         root_in_s = root_r;
         pair_s    = rad_r[RAD_WIDTH-1 -: 2];
      end
      step_s = sqrt_step(rem_in_s, root_in_s, pair_s);
   end

   // Iteration state: radicand shifter, remainder, partial root and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rad_r  <= '0;
         rem_r  <= '0;
         root_r <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         rad_r  <= {radicand[RAD_WIDTH-3:0], 2'b00};
         rem_r  <= step_s[REM_W+ROOT_W-1 -: REM_W];
         root_r <= step_s[ROOT_W-1:0];
         cnt_r  <= CNT_W'(ROOT_W - 1);
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (busy_r) begin
         rad_r  <= {rad_r[RAD_WIDTH-3:0], 2'b00};
         rem_r  <= step_s[REM_W+ROOT_W-1 -: REM_W];
         root_r <= step_s[ROOT_W-1:0];
         cnt_r  <= cnt_r - CNT_W'(1);
         if (cnt_r == CNT_W'(1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign root = root_r;

endmodule

// File: rtl/logit_approx.sv
// Inverse of the piecewise-quadratic sigmoid: x = +/-4*(1 - sqrt(2*d)).
// One sample in flight, valid/ready on both sides, square root computed bit-serially.
module logit_approx
   import logit_approx_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  o_ready
);

   // Radicand T<<F is 2F+1 bits wide, padded to an even width for the root engine.
   localparam int RAD_WIDTH  = 2 * FRAC_BITS + 2;
   localparam int ROOT_WIDTH = RAD_WIDTH / 2;

   localparam logic [FRAC_BITS:0]    ONE_F  = (FRAC_BITS+1)'(fp_one(FRAC_BITS));
   localparam logic [FRAC_BITS:0]    HALF_F = (FRAC_BITS+1)'(fp_half(FRAC_BITS));
   localparam logic [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(fp_one(FRAC_BITS));

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic                    ready_r;
   logic                    neg_r;
   logic [DATA_WIDTH-1:0]   o_data_r;
   logic                    o_valid_r;

   logic [FRAC_BITS:0]      pc_s;
   logic                    neg_s;
   logic [FRAC_BITS:0]      d_s;
   logic [FRAC_BITS:0]      t_s;
   logic [RAD_WIDTH-1:0]    rad_s;
   logic                    start_s;
   logic                    busy_s;
   logic                    done_s;
   logic [ROOT_WIDTH-1:0]   root_s;
   logic [DATA_WIDTH-1:0]   root_ext_s;
   logic [DATA_WIDTH-1:0]   m_s;
   logic [DATA_WIDTH-1:0]   x_s;

   // Clamp p into [0, ONE], fold onto the lower half and form the radicand 2*d<<F.
   always_comb begin
      pc_s = '0;
      if (i_data[DATA_WIDTH-1]) begin
         pc_s = '0;
      end else if (i_data > ONE_D) begin
         pc_s = ONE_F;
      end else begin
         pc_s = i_data[FRAC_BITS:0];
      end
      neg_s = (pc_s < HALF_F);
      if (neg_s) begin
         d_s = pc_s;
      end else begin
         d_s = ONE_F - pc_s;
      end
      t_s   = d_s << 1'b1;
      rad_s = {1'b0, t_s, {FRAC_BITS{1'b0}}};
   end

   // Scale the root back to the logit domain and apply the folded sign.
   always_comb begin
      root_ext_s = {{(DATA_WIDTH-ROOT_WIDTH){1'b0}}, root_s};
      m_s        = (ONE_D - root_ext_s) << 2'd2;
      if (neg_r) begin
         x_s = -m_s;
      end else begin
         x_s = m_s;
      end
   end

   isqrt_seq #(
      .RAD_WIDTH (RAD_WIDTH)
   ) u_isqrt (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_s),
      .radicand (rad_s),
      .busy     (busy_s),
      .done     (done_s),
      .root     (root_s)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and root-engine start strobe.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_valid && !busy_s) begin
               start_s     = 1'b1;
               state_nxt_s = ST_ITER;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ITER: begin
            if (done_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ITER;
            end
         end
         ST_DONE: begin
            if (o_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Registered input-ready, high exactly while the controller sits in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r <= 1'b1;
      end else begin
         ready_r <= (state_nxt_s == ST_IDLE);
      end
   end

   // Sign of the sample, captured on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_r <= 1'b0;
      end else if (start_s) begin
         neg_r <= neg_s;
      end else begin
         neg_r <= neg_r;
      end
   end

   // Output register: load when the root completes, hold until downstream accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data_r  <= '0;
         o_valid_r <= 1'b0;
      end else if ((state_r == ST_ITER) && done_s) begin
         o_data_r  <= x_s;
         o_valid_r <= 1'b1;
      end else if ((state_r == ST_DONE) && o_ready) begin
         o_data_r  <= o_data_r;
         o_valid_r <= 1'b0;
      end else begin
         o_data_r  <= o_data_r;
         o_valid_r <= o_valid_r;
      end
   end

   assign i_ready = ready_r;
   assign o_data  = o_data_r;
   assign o_valid = o_valid_r;

endmodule
